// File: rtl/axi4_lite_master_pkg.sv
// Shared definitions for the AXI4-Lite master: response codes and the
// state encodings of the independent write and read engines.
package axi4_lite_master_pkg;

    // AXI4-Lite BRESP / RRESP encodings
    localparam logic [1:0] RESP_OKAY   = 2'd0;
    localparam logic [1:0] RESP_EXOKAY = 2'd1;
    localparam logic [1:0] RESP_SLVERR = 2'd2;
    localparam logic [1:0] RESP_DECERR = 2'd3;

    // Write engine: idle, address+data channels open, waiting for B
    typedef enum logic [1:0] {
        W_IDLE      = 2'd0,
        W_ADDR_DATA = 2'd1,
        W_RESP      = 2'd2
    } w_state_t;

    // Read engine: idle, address channel open, waiting for R
    typedef enum logic [1:0] {
        R_IDLE = 2'd0,
        R_ADDR = 2'd1,
        R_DATA = 2'd2
    } r_state_t;

endpackage

// File: rtl/axi4_lite_master_if.sv
// AXI4-Lite bus bundle between one master and one slave.
//
// Handshake rule on every channel: a transfer happens on the rising clock
// edge where VALID and READY are both high. The source raises VALID without
// waiting for READY and then holds VALID and its payload stable until that
// edge; the sink may raise or drop READY at any time.
interface axi4_lite_master_if #(
    parameter int AXI_DATA_WIDTH = 32,
    parameter int AXI_ADDR_WIDTH = 32
);
    localparam int STRB_WIDTH = AXI_DATA_WIDTH / 8;

    // write address channel
    logic [AXI_ADDR_WIDTH-1:0] awaddr;
    logic [2:0]                awprot;
    logic                      awvalid;
    logic                      awready;
    // write data channel
    logic [AXI_DATA_WIDTH-1:0] wdata;
    logic [STRB_WIDTH-1:0]     wstrb;
    logic                      wvalid;
    logic                      wready;
    // write response channel
    logic [1:0]                bresp;
    logic                      bvalid;
    logic                      bready;
    // read address channel
    logic [AXI_ADDR_WIDTH-1:0] araddr;
    logic [2:0]                arprot;
    logic                      arvalid;
    logic                      arready;
    // read data channel
    logic [AXI_DATA_WIDTH-1:0] rdata;
    logic [1:0]                rresp;
    logic                      rvalid;
    logic                      rready;

    modport master (
        output awaddr, awprot, awvalid, input awready,
        output wdata, wstrb, wvalid,    input wready,
        input  bresp, bvalid,           output bready,
        output araddr, arprot, arvalid, input arready,
        input  rdata, rresp, rvalid,    output rready
    );

    modport slave (
        input  awaddr, awprot, awvalid, output awready,
        input  wdata, wstrb, wvalid,    output wready,
        output bresp, bvalid,           input bready,
        input  araddr, arprot, arvalid, output arready,
        output rdata, rresp, rvalid,    input rready
    );

endinterface

// File: rtl/axi4_lite_master.sv
// Single-outstanding AXI4-Lite master. A one-cycle wr_start / rd_start
// launches one write / read transaction; the two engines are fully
// independent and may be busy at the same time. Starts that arrive while an
// engine is busy are dropped, not queued. There is no timeout: a slave that
// never answers leaves the engine busy until reset.
module axi4_lite_master
    import axi4_lite_master_pkg::*;
#(
    parameter int AXI_DATA_WIDTH = 32,
    parameter int AXI_ADDR_WIDTH = 32
) (
    input  logic                      AXI_ACLK,
    input  logic                      AXI_ARESETN,
    // user write command
    input  logic [AXI_ADDR_WIDTH-1:0] wr_addr,
    input  logic [AXI_DATA_WIDTH-1:0] wr_data,
    input  logic                      wr_start,
    output logic                      wr_idle,
    output logic [1:0]                wr_resp,
    // user read command
    input  logic [AXI_ADDR_WIDTH-1:0] rd_addr,
    input  logic                      rd_start,
    output logic                      rd_idle,
    output logic [AXI_DATA_WIDTH-1:0] rd_data,
    output logic [1:0]                rd_resp,
    // engine state, exposed for observation
    output w_state_t                  wr_state,
    output r_state_t                  rd_state,
    // AXI4-Lite bus
    axi4_lite_master_if.master        m_axi
);

    // ------------------------------------------------------------------
    // Write engine registers
    // ------------------------------------------------------------------
    w_state_t                  w_state_q, w_state_d;
    logic [AXI_ADDR_WIDTH-1:0] awaddr_q,  awaddr_d;
    logic [AXI_DATA_WIDTH-1:0] wdata_q,   wdata_d;
    logic                      awvalid_q, awvalid_d;
    logic                      wvalid_q,  wvalid_d;
    logic [1:0]                wr_resp_q, wr_resp_d;

    logic aw_hs;
    logic w_hs;
    logic b_hs;
    logic bready;

    // BREADY is simply "waiting for the response", so it is a decode of the
    // registered state and rises the cycle after the later of AW/W.
    assign bready = (w_state_q == W_RESP);
    assign aw_hs  = awvalid_q && m_axi.awready;
    assign w_hs   = wvalid_q  && m_axi.wready;
    assign b_hs   = bready    && m_axi.bvalid;

    // Write engine state register
    always_ff @(posedge AXI_ACLK or negedge AXI_ARESETN) begin
        if (!AXI_ARESETN) begin
            w_state_q <= W_IDLE;
            awaddr_q  <= '0;
            wdata_q   <= '0;
            awvalid_q <= 1'b0;
            wvalid_q  <= 1'b0;
            wr_resp_q <= RESP_OKAY;
        end else begin
            w_state_q <= w_state_d;
            awaddr_q  <= awaddr_d;
            wdata_q   <= wdata_d;
            awvalid_q <= awvalid_d;
            wvalid_q  <= wvalid_d;
            wr_resp_q <= wr_resp_d;
        end
    end

    // Write engine next state: AW and W retire independently; a channel
    // whose VALID is already low has finished its handshake.
    always_comb begin
        w_state_d = w_state_q;
        awaddr_d  = awaddr_q;
        wdata_d   = wdata_q;
        awvalid_d = awvalid_q;
        wvalid_d  = wvalid_q;
        wr_resp_d = wr_resp_q;
        case (w_state_q)
            W_IDLE: begin
                if (wr_start) begin
                    awaddr_d  = wr_addr;
                    wdata_d   = wr_data;
                    awvalid_d = 1'b1;
                    wvalid_d  = 1'b1;
                    w_state_d = W_ADDR_DATA;
                end
            end
            W_ADDR_DATA: begin
                if (aw_hs) begin
                    awvalid_d = 1'b0;
                end
                if (w_hs) begin
                    wvalid_d = 1'b0;
                end
                if ((!awvalid_q || aw_hs) && (!wvalid_q || w_hs)) begin
                    w_state_d = W_RESP;
                end
            end
            W_RESP: begin
                if (b_hs) begin
                    wr_resp_d = m_axi.bresp;
                    w_state_d = W_IDLE;
                end
            end
            default: begin
                w_state_d = W_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Read engine registers
    // ------------------------------------------------------------------
    r_state_t                  r_state_q, r_state_d;
    logic [AXI_ADDR_WIDTH-1:0] araddr_q,  araddr_d;
    logic                      arvalid_q, arvalid_d;
    logic [AXI_DATA_WIDTH-1:0] rd_data_q, rd_data_d;
    logic [1:0]                rd_resp_q, rd_resp_d;

    logic ar_hs;
    logic r_hs;
    logic rready;

    // RREADY is high exactly while waiting for read data.
    assign rready = (r_state_q == R_DATA);
    assign ar_hs  = arvalid_q && m_axi.arready;
    assign r_hs   = rready    && m_axi.rvalid;

    // Read engine state register
    always_ff @(posedge AXI_ACLK or negedge AXI_ARESETN) begin
        if (!AXI_ARESETN) begin
            r_state_q <= R_IDLE;
            araddr_q  <= '0;
            arvalid_q <= 1'b0;
            rd_data_q <= '0;
            rd_resp_q <= RESP_OKAY;
        end else begin
            r_state_q <= r_state_d;
            araddr_q  <= araddr_d;
            arvalid_q <= arvalid_d;
            rd_data_q <= rd_data_d;
            rd_resp_q <= rd_resp_d;
        end
    end

    // Read engine next state: address phase, then data phase
    always_comb begin
        r_state_d = r_state_q;
        araddr_d  = araddr_q;
        arvalid_d = arvalid_q;
        rd_data_d = rd_data_q;
        rd_resp_d = rd_resp_q;
        case (r_state_q)
            R_IDLE: begin
                if (rd_start) begin
                    araddr_d  = rd_addr;
                    arvalid_d = 1'b1;
                    r_state_d = R_ADDR;
                end
            end
            R_ADDR: begin
                if (ar_hs) begin
                    arvalid_d = 1'b0;
                    r_state_d = R_DATA;
                end
            end
            R_DATA: begin
                if (r_hs) begin
                    rd_data_d = m_axi.rdata;
                    rd_resp_d = m_axi.rresp;
                    r_state_d = R_IDLE;
                end
            end
            default: begin
                r_state_d = R_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Outputs: everything comes straight from registers
    // ------------------------------------------------------------------
    assign m_axi.awaddr  = awaddr_q;
    assign m_axi.awprot  = 3'b000;
    assign m_axi.awvalid = awvalid_q;
    assign m_axi.wdata   = wdata_q;
    assign m_axi.wstrb   = '1;
    assign m_axi.wvalid  = wvalid_q;
    assign m_axi.bready  = bready;
    assign m_axi.araddr  = araddr_q;
    assign m_axi.arprot  = 3'b000;
    assign m_axi.arvalid = arvalid_q;
    assign m_axi.rready  = rready;

    assign wr_idle  = (w_state_q == W_IDLE);
    assign wr_resp  = wr_resp_q;
    assign rd_idle  = (r_state_q == R_IDLE);
    assign rd_data  = rd_data_q;
    assign rd_resp  = rd_resp_q;
    assign wr_state = w_state_q;
    assign rd_state = r_state_q;

endmodule

// File: tb/tb_axi4_lite_master.sv
// Directed bench for axi4_lite_master with a small registered AXI4-Lite
// slave model whose READY / response behaviour is steered per test.
module tb_axi4_lite_master;
    import axi4_lite_master_pkg::*;

    localparam int DW = 32;
    localparam int AW = 32;

    // ---------------- clock / reset ----------------
    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    // ---------------- DUT hookup ----------------
    logic [AW-1:0] wr_addr  = '0;
    logic [DW-1:0] wr_data  = '0;
    logic          wr_start = 1'b0;
    logic          wr_idle;
    logic [1:0]    wr_resp;
    logic [AW-1:0] rd_addr  = '0;
    logic          rd_start = 1'b0;
    logic          rd_idle;
    logic [DW-1:0] rd_data;
    logic [1:0]    rd_resp;
    w_state_t      wr_state;
    r_state_t      rd_state;

    axi4_lite_master_if #(.AXI_DATA_WIDTH(DW), .AXI_ADDR_WIDTH(AW)) bus ();

    axi4_lite_master #(.AXI_DATA_WIDTH(DW), .AXI_ADDR_WIDTH(AW)) dut (
        .AXI_ACLK    (clk),
        .AXI_ARESETN (rst_n),
        .wr_addr     (wr_addr),
        .wr_data     (wr_data),
        .wr_start    (wr_start),
        .wr_idle     (wr_idle),
        .wr_resp     (wr_resp),
        .rd_addr     (rd_addr),
        .rd_start    (rd_start),
        .rd_idle     (rd_idle),
        .rd_data     (rd_data),
        .rd_resp     (rd_resp),
        .wr_state    (wr_state),
        .rd_state    (rd_state),
        .m_axi       (bus.master)
    );

    // ---------------- slave model ----------------
    logic          awready_en = 1'b1;
    logic          wready_en  = 1'b1;
    logic          arready_en = 1'b1;
    logic          b_hold     = 1'b0;
    logic [1:0]    bresp_cfg  = RESP_OKAY;
    logic          b_inject   = 1'b0;
    logic [1:0]    b_inject_resp = RESP_DECERR;

    logic          aw_seen, w_seen, bvalid_q, rvalid_q;
    logic [1:0]    bresp_q, rresp_q;
    logic [DW-1:0] rdata_q;
    int            ar_count;

    function automatic logic [DW-1:0] slave_rdata(input logic [AW-1:0] a);
        case (a)
            32'h0:   return 32'd17;
            32'h4:   return 32'd76;
            32'h8:   return 32'd42;
            32'hC:   return 32'h0DEC0DE0;
            default: return 32'hDEADBEEF;
        endcase
    endfunction

    assign bus.awready = awready_en;
    assign bus.wready  = wready_en;
    assign bus.arready = arready_en;
    assign bus.bvalid  = bvalid_q | b_inject;
    assign bus.bresp   = b_inject ? b_inject_resp : bresp_q;
    assign bus.rvalid  = rvalid_q;
    assign bus.rdata   = rdata_q;
    assign bus.rresp   = rresp_q;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            aw_seen  <= 1'b0;
            w_seen   <= 1'b0;
            bvalid_q <= 1'b0;
            bresp_q  <= RESP_OKAY;
        end else begin
            if (bus.awvalid && bus.awready) aw_seen <= 1'b1;
            if (bus.wvalid && bus.wready)   w_seen  <= 1'b1;
            if ((aw_seen || (bus.awvalid && bus.awready)) &&
                (w_seen  || (bus.wvalid  && bus.wready)) && !bvalid_q && !b_hold) begin
                bvalid_q <= 1'b1;
                bresp_q  <= bresp_cfg;
                aw_seen  <= 1'b0;
                w_seen   <= 1'b0;
            end
            if (bvalid_q && bus.bready) bvalid_q <= 1'b0;
        end
    end

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rvalid_q <= 1'b0;
            rdata_q  <= '0;
            rresp_q  <= RESP_OKAY;
            ar_count <= 0;
        end else begin
            if (bus.arvalid && bus.arready) begin
                rvalid_q <= 1'b1;
                rdata_q  <= slave_rdata(bus.araddr);
                rresp_q  <= (bus.araddr == 32'hC) ? RESP_SLVERR : RESP_OKAY;
                ar_count <= ar_count + 1;
            end else if (rvalid_q && bus.rready) begin
                rvalid_q <= 1'b0;
            end
        end
    end

    // ---------------- scoreboard ----------------
    logic [DW-1:0] exp_q[$];
    int assert_count = 0;
    int fail_count   = 0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        assert_count++;
        if (got !== exp) begin
            fail_count++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic wait_rd_idle(output int n);
        n = 0;
        while (!rd_idle && n < 50) begin
            @(negedge clk);
            n++;
        end
        check_eq("rd_idle_in_time", rd_idle, 1'b1);
    endtask

    task automatic wait_wr_idle(output int n);
        n = 0;
        while (!wr_idle && n < 50) begin
            @(negedge clk);
            n++;
        end
        check_eq("wr_idle_in_time", wr_idle, 1'b1);
    endtask

    // One read; expected data comes from exp_q. ARREADY is held low for
    // 'stall' cycles after ARVALID rises. Latency is checked when stall=0.
    task automatic do_read(input logic [AW-1:0] addr, input int stall, input logic [1:0] exp_resp);
        int n;
        logic [DW-1:0] exp_d;
        arready_en = (stall == 0);
        @(negedge clk);
        rd_addr  = addr;
        rd_start = 1'b1;
        @(negedge clk);
        rd_start = 1'b0;
        check_eq("rd_busy", rd_idle, 1'b0);
        check_eq("araddr", bus.araddr, addr);
        for (int i = 0; i < stall; i++) begin
            check_eq("arvalid_held", bus.arvalid, 1'b1);
            check_eq("araddr_stable", bus.araddr, addr);
            check_eq("rready_low_in_addr", bus.rready, 1'b0);
            @(negedge clk);
        end
        arready_en = 1'b1;
        wait_rd_idle(n);
        if (stall == 0) check_eq("rd_latency", 64'(n + 1), 64'd3);
        exp_d = exp_q.pop_front();
        check_eq("rd_data", rd_data, exp_d);
        check_eq("rd_resp", rd_resp, exp_resp);
        check_eq("arprot", bus.arprot, 3'b000);
    endtask

    // ---------------- test sequence ----------------
    initial begin
        int n;
        int ar_base;

        // reset state
        repeat (3) @(negedge clk);
        check_eq("rst_awvalid", bus.awvalid, 1'b0);
        check_eq("rst_wvalid",  bus.wvalid,  1'b0);
        check_eq("rst_bready",  bus.bready,  1'b0);
        check_eq("rst_arvalid", bus.arvalid, 1'b0);
        check_eq("rst_rready",  bus.rready,  1'b0);
        check_eq("rst_wr_idle", wr_idle, 1'b1);
        check_eq("rst_rd_idle", rd_idle, 1'b1);
        check_eq("rst_wr_resp", wr_resp, 2'd0);
        check_eq("rst_rd_resp", rd_resp, 2'd0);
        check_eq("rst_rd_data", rd_data, 32'd0);
        check_eq("rst_awaddr",  bus.awaddr, 32'd0);
        check_eq("rst_wdata",   bus.wdata,  32'd0);
        check_eq("rst_araddr",  bus.araddr, 32'd0);
        check_eq("rst_wstrb",   bus.wstrb,  4'hF);
        check_eq("rst_awprot",  bus.awprot, 3'b000);
        check_eq("rst_wr_state", wr_state, W_IDLE);
        check_eq("rst_rd_state", rd_state, R_IDLE);
        rst_n = 1'b1;
        @(negedge clk);

        // zero-wait reads
        exp_q.push_back(32'd17);
        do_read(32'h0, 0, RESP_OKAY);
        exp_q.push_back(32'd76);
        do_read(32'h4, 0, RESP_OKAY);
        exp_q.push_back(32'd42);
        do_read(32'h8, 0, RESP_OKAY);

        // stalled read with error response
        exp_q.push_back(32'h0DEC0DE0);
        do_read(32'hC, 5, RESP_SLVERR);

        // zero-wait write, SLVERR response, minimum latency
        bresp_cfg = RESP_SLVERR;
        @(negedge clk);
        wr_addr  = 32'h10;
        wr_data  = 32'h1234_5678;
        wr_start = 1'b1;
        @(negedge clk);
        wr_start = 1'b0;
        check_eq("w0_awaddr", bus.awaddr, 32'h10);
        check_eq("w0_wdata",  bus.wdata,  32'h1234_5678);
        wait_wr_idle(n);
        check_eq("w0_latency", 64'(n + 1), 64'd3);
        check_eq("w0_wr_resp", wr_resp, RESP_SLVERR);

        // write: W accepted 4 cycles before AW
        bresp_cfg  = RESP_OKAY;
        awready_en = 1'b0;
        wready_en  = 1'b1;
        @(negedge clk);
        wr_addr  = 32'h4;
        wr_data  = 32'hA5A5_A5A5;
        wr_start = 1'b1;
        @(negedge clk);
        wr_start = 1'b0;
        check_eq("w1_awvalid_up", bus.awvalid, 1'b1);
        check_eq("w1_wvalid_up",  bus.wvalid,  1'b1);
        check_eq("w1_awaddr", bus.awaddr, 32'h4);
        check_eq("w1_wdata",  bus.wdata,  32'hA5A5_A5A5);
        check_eq("w1_wstrb",  bus.wstrb,  4'hF);
        check_eq("w1_wr_idle", wr_idle, 1'b0);
        @(negedge clk);
        check_eq("w1_wvalid_dropped", bus.wvalid, 1'b0);
        for (int i = 0; i < 3; i++) begin
            check_eq("w1_awvalid_held", bus.awvalid, 1'b1);
            check_eq("w1_bready_wait",  bus.bready,  1'b0);
            check_eq("w1_awaddr_stable", bus.awaddr, 32'h4);
            @(negedge clk);
        end
        check_eq("w1_bready_before_aw", bus.bready, 1'b0);
        awready_en = 1'b1;
        @(negedge clk);
        check_eq("w1_awvalid_dropped", bus.awvalid, 1'b0);
        check_eq("w1_bready_up", bus.bready, 1'b1);
        wait_wr_idle(n);
        check_eq("w1_wr_resp", wr_resp, RESP_OKAY);
        check_eq("w1_bready_down", bus.bready, 1'b0);

        // concurrent write + read, then a read start while busy
        bresp_cfg = RESP_EXOKAY;
        ar_base   = ar_count;
        exp_q.push_back(32'd76);
        @(negedge clk);
        wr_addr  = 32'h8;
        wr_data  = 32'hCAFE_F00D;
        wr_start = 1'b1;
        rd_addr  = 32'h4;
        rd_start = 1'b1;
        @(negedge clk);
        wr_start = 1'b0;
        rd_addr  = 32'h8;
        check_eq("cc_wr_busy", wr_idle, 1'b0);
        check_eq("cc_rd_busy", rd_idle, 1'b0);
        @(negedge clk);
        rd_start = 1'b0;
        check_eq("cc_arvalid_dropped", bus.arvalid, 1'b0);
        check_eq("cc_araddr_kept", bus.araddr, 32'h4);
        wait_rd_idle(n);
        wait_wr_idle(n);
        repeat (3) @(negedge clk);
        check_eq("cc_arvalid_quiet", bus.arvalid, 1'b0);
        check_eq("cc_ar_count", 64'(ar_count - ar_base), 64'd1);
        check_eq("cc_rd_data", rd_data, exp_q.pop_front());
        check_eq("cc_rd_resp", rd_resp, RESP_OKAY);
        check_eq("cc_wr_resp", wr_resp, RESP_EXOKAY);

        // stray BVALID while idle is never acknowledged
        b_inject_resp = RESP_DECERR;
        b_inject      = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check_eq("inj_bready", bus.bready, 1'b0);
            check_eq("inj_wr_resp", wr_resp, RESP_EXOKAY);
            check_eq("inj_wr_idle", wr_idle, 1'b1);
        end
        b_inject = 1'b0;

        // asynchronous reset with ARVALID and BREADY both high
        arready_en = 1'b0;
        b_hold     = 1'b1;
        @(negedge clk);
        wr_addr  = 32'h20;
        wr_data  = 32'h5555_AAAA;
        wr_start = 1'b1;
        rd_addr  = 32'h0;
        rd_start = 1'b1;
        @(negedge clk);
        wr_start = 1'b0;
        rd_start = 1'b0;
        @(negedge clk);
        check_eq("pre_rst_arvalid", bus.arvalid, 1'b1);
        check_eq("pre_rst_bready",  bus.bready,  1'b1);
        rst_n = 1'b0;
        #1;
        check_eq("arst_arvalid", bus.arvalid, 1'b0);
        check_eq("arst_bready",  bus.bready,  1'b0);
        check_eq("arst_awvalid", bus.awvalid, 1'b0);
        check_eq("arst_wvalid",  bus.wvalid,  1'b0);
        check_eq("arst_rready",  bus.rready,  1'b0);
        check_eq("arst_wr_idle", wr_idle, 1'b1);
        check_eq("arst_rd_idle", rd_idle, 1'b1);
        check_eq("arst_wr_resp", wr_resp, 2'd0);
        check_eq("arst_rd_data", rd_data, 32'd0);
        check_eq("arst_awaddr",  bus.awaddr, 32'd0);
        @(negedge clk);
        rst_n      = 1'b1;
        arready_en = 1'b1;
        b_hold     = 1'b0;
        @(negedge clk);

        // engine usable again after reset
        exp_q.push_back(32'd42);
        do_read(32'h8, 0, RESP_OKAY);

        $display("End of test - %0d assertions evaluated, %0d failures", assert_count, fail_count);
        $finish;
    end

    // global watchdog
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "bench did not finish");
    end

endmodule

// File: doc/axi4_lite_master.md
Name: axi4_lite_master

Overview:
- Single-outstanding AXI4-Lite master that converts simple user start/idle commands into AXI4-Lite read and write transactions.
- Sits directly upstream of our AXI4-Lite slave blocks.
- Used by in-fabric controllers and benches to drive register-mapped peripherals without hand-coding channel handshakes.
- Read and write engines are independent and may run concurrently.

Parameters:
AXI_DATA_WIDTH, 32, width of WDATA/RDATA (multiple of 8)
AXI_ADDR_WIDTH, 32, width of AWADDR/ARADDR

Ports:
AXI_ACLK  in  1  clock, all logic on rising edge
AXI_ARESETN  in  1  asynchronous active-low reset
wr_addr  in  AXI_ADDR_WIDTH  write address, sampled on wr_start
wr_data  in  AXI_DATA_WIDTH  write data, sampled on wr_start
wr_start  in  1  1-cycle request to begin a write
wr_idle  out  1  high when write engine idle/done
wr_resp  out  2  BRESP of last completed write
rd_addr  in  AXI_ADDR_WIDTH  read address, sampled on rd_start
rd_start  in  1  1-cycle request to begin a read
rd_idle  out  1  high when read engine idle/done
rd_data  out  AXI_DATA_WIDTH  RDATA of last completed read
rd_resp  out  2  RRESP of last completed read
M_AXI_AWADDR/AWVALID/AWPROT  out  ADDR/1/3  write address channel
M_AXI_AWREADY  in  1
M_AXI_WDATA/WSTRB/WVALID  out  DATA/DATA/8/1  write data channel
M_AXI_WREADY  in  1
M_AXI_BRESP  in  2;  M_AXI_BVALID  in  1;  M_AXI_BREADY  out  1
M_AXI_ARADDR/ARVALID/ARPROT  out  ADDR/1/3  read address channel
M_AXI_ARREADY  in  1
M_AXI_RDATA  in  DATA;  M_AXI_RRESP  in  2;  M_AXI_RVALID  in  1;  M_AXI_RREADY  out  1

Behaviour:
- Reset (async assert, sync-to-clock deassert use):
  - all VALID and READY outputs 0.
  - wr_idle = rd_idle = 1.
  - wr_resp = rd_resp = 0; rd_data = 0.
  - AWADDR = WDATA = ARADDR = 0.
- Constant outputs: AWPROT = ARPROT = 0; WSTRB = all ones.
- Write FSM states W_IDLE, W_ADDR_DATA, W_RESP.
  - W_IDLE: on wr_start, register wr_addr/wr_data onto AWADDR/WDATA, assert AWVALID and WVALID, drop wr_idle (same edge). Go W_ADDR_DATA.
  - W_ADDR_DATA: AW and W handshakes are tracked independently. On the edge where AWVALID&AWREADY, AWVALID drops next cycle. Same rule for WVALID&WREADY. Handshakes may occur in either order or the same cycle. When both are done, assert BREADY and go W_RESP. BREADY is first high in the cycle after the later handshake.
  - W_RESP: on BVALID&BREADY edge, capture BRESP into wr_resp, drop BREADY, raise wr_idle, go W_IDLE.
  - Minimum latency with zero-wait slave: wr_start edge to wr_idle high = 3 cycles.
- Read FSM states R_IDLE, R_ADDR, R_DATA.
  - R_IDLE: on rd_start, register rd_addr onto ARADDR, assert ARVALID, drop rd_idle. Go R_ADDR.
  - R_ADDR: on ARVALID&ARREADY edge, drop ARVALID, assert RREADY, go R_DATA.
  - R_DATA: on RVALID&RREADY edge, capture RDATA/RRESP into rd_data/rd_resp, drop RREADY, raise rd_idle, go R_IDLE.
  - Minimum latency: 3 cycles.
- VALID, once asserted, is held with its address/data stable until its handshake (AXI rule).
- wr_start while not in W_IDLE is ignored. Same for rd_start when not in R_IDLE. No queueing.
- wr_start and rd_start in the same cycle: both engines start. There is no shared arbitration.
- rd_data/rd_resp/wr_resp hold their last values until the next completion.
- BVALID or RVALID arriving while not in the accepting state is never acknowledged (READY low).
- Reset mid-transaction: immediate return to reset values. An outstanding transaction is abandoned; the slave is reset together with the master by convention.
- No timeout. A hung slave leaves the engine busy indefinitely.

Decomposition:
- Shared package holds:
  - response codes OKAY=0, EXOKAY=1, SLVERR=2, DECERR=3
  - write and read FSM state encodings.
- No sub-module. The two FSMs are separate always blocks in one module.

Test Plan:
- Zero-wait slave, rd_start with rd_addr=0x0, then 0x4, then 0x8 -> rd_data 17, 76, 42, rd_resp=OKAY, rd_idle high 3 cycles after each start.
- rd_addr=0xC -> rd_data=0x0DEC0DE0, rd_resp=SLVERR (2). ARVALID held through 5 ARREADY-low cycles with ARADDR stable.
- wr_start addr=0x4 data=0xA5A5A5A5, WREADY 4 cycles before AWREADY -> each VALID drops the cycle after its own handshake. BREADY is not asserted until both are done. Slave BRESP=OKAY gives wr_resp=0, WSTRB=0xF.
- wr_start and rd_start in the same cycle, then a second rd_start while busy -> both complete independently; the second rd_start produces no ARVALID.
- AXI_ARESETN low while ARVALID and BREADY are high -> all VALID/READY outputs 0 and both idles 1 asynchronously, before the next clock edge.
- BVALID injected while in W_IDLE -> BREADY stays 0 and wr_resp is unchanged.
